// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and the
// memory arbiter grant state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared RAM port.
// Optional feature macro: ARB_FAIRNESS_EN bounds instruction starvation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DSTREAK_MAX = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    // The streak counter is 4 bits wide, so the limit must fit in 1..15.
    if (DSTREAK_MAX < 1 || DSTREAK_MAX > 15) begin : g_bad_dstreak_max
        $error("mem_arbiter: DSTREAK_MAX must be in 1..15");
    end

    arb_state_t state_q, state_d;
    logic       d_req;
    logic       ram_done;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_LIMIT = 4'(DSTREAK_MAX);

    logic [3:0] dstreak_q, dstreak_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef ARB_FAIRNESS_EN
        dstreak_d = dstreak_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_FAIRNESS_EN
                // Streak counts data wins only while a fetch is actually waiting.
                if (iREN && (dstreak_q == STREAK_LIMIT)) begin
                    state_d   = IGRANT;
                    dstreak_d = 4'd0;
                end else if (d_req) begin
                    state_d   = DGRANT;
                    dstreak_d = iREN ? dstreak_q + 4'd1 : 4'd0;
                end else begin
                    state_d   = iREN ? IGRANT : IDLE;
                    dstreak_d = 4'd0;
                end
`else
                if (d_req) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
`endif
            end
            DGRANT: begin
                if (ram_done || !d_req) begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (ram_done || !iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the grant state and the live requester inputs, so a
    // dropped request releases the RAM enables in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_done;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~ram_done;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; expected grant order adapts
// to whether ARB_FAIRNESS_EN is defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      iREN = 1'b0;
    word_t     iaddr = '0;
    logic      iwait;
    word_t     iload;
    logic      dREN = 1'b0;
    logic      dWEN = 1'b0;
    word_t     daddr = '0;
    word_t     dstore = '0;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload = '0;
    ramstate_t ramstate = FREE;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic  is_d;
        word_t addr;
        logic  we;
        word_t store;
        word_t load;
    } exp_t;

    exp_t sb[$];

    mem_arbiter #(.DSTREAK_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input word_t addr, input logic we,
                        input word_t store, input word_t load);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.we = we; e.store = store; e.load = load;
        sb.push_back(e);
    endtask

    task automatic check_done(input logic is_d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_completion observed=port%0d expected=none", is_d);
        end else begin
            e = sb.pop_front();
            chk("done_port", {31'd0, is_d}, {31'd0, e.is_d});
            chk("done_addr", ramaddr, e.addr);
            chk("done_wen", {31'd0, ramWEN}, {31'd0, e.we});
            chk("done_ren", {31'd0, ramREN}, {31'd0, ~e.we});
            chk("done_store", ramstore, e.store);
            chk("done_load", is_d ? dload : iload, e.load);
            $display("txn %s addr=%08h we=%0d load=%08h", is_d ? "D" : "I", ramaddr, ramWEN,
                     is_d ? dload : iload);
        end
    endtask

    // Completion monitor: every low wait must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dwait === 1'b0) check_done(1'b1);
            if (iwait === 1'b0) check_done(1'b0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ren"}, {31'd0, ramREN}, 32'd0);
        chk({tag, "_wen"}, {31'd0, ramWEN}, 32'd0);
        chk({tag, "_addr"}, ramaddr, 32'd0);
        chk({tag, "_iwait"}, {31'd0, iwait}, 32'd1);
        chk({tag, "_dwait"}, {31'd0, dwait}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        @(negedge CLK);
        chk_idle("reset");

        // Reset in the middle of a stalled data grant
        tick();
        RST = 1'b0; dREN = 1'b1; daddr = 32'h0000_0200; ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("rst_pre_ren", {31'd0, ramREN}, 32'd1);
        chk("rst_pre_addr", ramaddr, 32'h0000_0200);
        RST = 1'b1;
        tick();
        @(negedge CLK);
        chk_idle("rst_mid");
        tick();
        RST = 1'b0; dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        chk_idle("rst_release");

        // Single fetch with immediate ACCESS
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = ACCESS; ramload = 32'h2408_0001;
        push(1'b0, 32'h0000_0040, 1'b0, 32'h0, 32'h2408_0001);
        tick();
        @(negedge CLK);
        chk("fetch_ren", {31'd0, ramREN}, 32'd1);
        chk("fetch_iwait", {31'd0, iwait}, 32'd0);
        chk("fetch_dwait", {31'd0, dwait}, 32'd1);
        tick();
        iREN = 1'b0;
        @(negedge CLK);
        chk_idle("fetch_after");

        // Contention: data wins, then one idle turnaround, then fetch
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0044;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        ramload = 32'h1111_2222;
        push(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h1111_2222);
        push(1'b0, 32'h0000_0044, 1'b0, 32'h0, 32'h1111_2222);
        tick();
        @(negedge CLK);
        chk("cont_iwait_in_d", {31'd0, iwait}, 32'd1);
        tick();
        dWEN = 1'b0; dstore = '0;
        @(negedge CLK);
        chk_idle("cont_turnaround");
        tick();
        @(negedge CLK);
        chk("cont_igrant_ren", {31'd0, ramREN}, 32'd1);
        tick();
        iREN = 1'b0;
        @(negedge CLK);
        chk_idle("cont_after");

        // Wait states: BUSY x3, ERROR x1, then ACCESS
        tick();
        dREN = 1'b1; daddr = 32'h0000_0300; ramstate = BUSY; ramload = 32'hCAFE_0000;
        push(1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'hCAFE_0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) ramstate = ERROR;
            @(negedge CLK);
            chk($sformatf("ws_dwait_%0d", k), {31'd0, dwait}, 32'd1);
            chk($sformatf("ws_ren_%0d", k), {31'd0, ramREN}, 32'd1);
        end
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        chk("ws_dwait_5", {31'd0, dwait}, 32'd0);
        tick();
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        chk_idle("ws_after");

        // Abort: data request drops while RAM is busy
        tick();
        dREN = 1'b1; daddr = 32'h0000_0400; ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("abort_ren_before", {31'd0, ramREN}, 32'd1);
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        chk("abort_ren_same", {31'd0, ramREN}, 32'd0);
        chk("abort_dwait", {31'd0, dwait}, 32'd1);
        chk("abort_addr_held", ramaddr, 32'h0000_0400);
        tick();
        @(negedge CLK);
        chk_idle("abort_idle");

        // Continuous contention: fairness pattern or strict data priority
        tick();
        iREN = 1'b1; iaddr = 32'h0000_0080;
        dREN = 1'b1; daddr = 32'h0000_0500;
        ramstate = ACCESS; ramload = 32'h5A5A_0000;
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_FAIRNESS_EN
            if (g == 4) push(1'b0, 32'h0000_0080, 1'b0, 32'h0, 32'h5A5A_0000);
            else        push(1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h5A5A_0000);
`else
            push(1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h5A5A_0000);
`endif
        end
        for (int g = 0; g < 6; g++) begin
            tick();
            @(negedge CLK);
            tick();
            @(negedge CLK);
            chk($sformatf("fair_turn_%0d", g), {31'd0, ramREN}, 32'd0);
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();
        @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
